// File: rtl/msg_pkg.sv
// Shared constants, state encoding and message text for the message streamer.
package msg_pkg;

  localparam int unsigned MSG_LEN = 51;

  localparam logic [7:0] FILL_CHAR = 8'h20;

  // Index 0 is the leftmost character of the literal.
  localparam logic [MSG_LEN*8-1:0] MSG_TEXT =
    "Tajumulco Tacana Acatenango Fuego Santa Maria Agua ";

  typedef enum logic [1:0] {
    IDLE,
    PACE,
    SEND
  } state_t;

  // Character lookup; anything past the stored text reads as a space.
  function automatic logic [7:0] msg_char(input int unsigned i);
    logic [7:0] c;
    c = FILL_CHAR;
    if (i < MSG_LEN) c = MSG_TEXT[(MSG_LEN - 1 - i) * 8 +: 8];
    return c;
  endfunction

endpackage

// File: rtl/msg_streamer_if.sv
// Character stream handshake between the streamer and its consumer.
interface msg_streamer_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/msg_rom.sv
// Combinational index-to-character lookup of the constant message.
module msg_rom #(
  parameter int unsigned MSG_LEN = 51,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned IDX_W   = $clog2(MSG_LEN)
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] ch
);
  import msg_pkg::*;

  // Out-of-range indices read as a space rather than past the table.
  always_comb begin
    ch = DATA_W'(FILL_CHAR);
    if (32'(idx) < MSG_LEN) ch = DATA_W'(msg_char(32'(idx)));
  end
endmodule

// File: rtl/msg_streamer.sv
// Paced valid/ready streamer walking the message ROM, one-shot or looping.
module msg_streamer #(
  parameter int unsigned  MSG_LEN = msg_pkg::MSG_LEN,
  parameter int unsigned  DATA_W  = 8,
  parameter int unsigned  DIV_W   = 16,
  localparam int unsigned IDX_W   = $clog2(MSG_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             mode_loop,
  input  logic [DIV_W-1:0] div,
  msg_streamer_if.master   stream,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] idx
);
  import msg_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              loop_q, loop_d;
  logic [IDX_W-1:0]  idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_d;
  logic              done_d;
  logic [DATA_W-1:0] rom_ch;

  msg_rom #(
    .MSG_LEN(MSG_LEN),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_rom (
    .idx(idx),
    .ch (rom_ch)
  );

  assign stream.out_data  = data_q;
  assign stream.out_valid = valid_q;

  // Next-state and registered-output decode; stop outranks a same-cycle handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    loop_d  = loop_q;
    idx_d   = idx;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && en) begin
          loop_d  = mode_loop;
          div_d   = div;
          idx_d   = '0;
          cnt_d   = div;
          busy_d  = 1'b1;
          state_d = PACE;
        end
      end
      PACE: begin
        if (stop) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = IDLE;
        end else if (en) begin
          if (cnt_q == '0) begin
            data_d  = rom_ch;
            valid_d = 1'b1;
            state_d = SEND;
          end else begin
            cnt_d = cnt_q - DIV_W'(1);
          end
        end
      end
      SEND: begin
        if (stop) begin
          valid_d = 1'b0;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = IDLE;
        end else if (valid_q && stream.out_ready) begin
          valid_d = 1'b0;
          if (idx != LAST_IDX) begin
            idx_d   = idx + IDX_W'(1);
            cnt_d   = div_q;
            state_d = PACE;
          end else if (loop_q) begin
            idx_d   = '0;
            cnt_d   = div_q;
            state_d = PACE;
          end else begin
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      loop_q  <= 1'b0;
      idx     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      loop_q  <= loop_d;
      idx     <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end
endmodule

// File: tb/tb_msg_streamer.sv
// Directed bench for msg_streamer: pacing table plus multi-cycle sequences.
module tb_msg_streamer;
  localparam int DIV_W = 16;
  localparam int IDX_W = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             start;
  logic             stop;
  logic             mode_loop;
  logic [DIV_W-1:0] div;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] idx;

  msg_streamer_if #(.DATA_W(8)) s_if ();

  msg_streamer #(
    .MSG_LEN(51),
    .DATA_W (8),
    .DIV_W  (DIV_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .start    (start),
    .stop     (stop),
    .mode_loop(mode_loop),
    .div      (div),
    .stream   (s_if),
    .busy     (busy),
    .done     (done),
    .idx      (idx)
  );

  always #5 clk = ~clk;

  string msg_s = "Tajumulco Tacana Acatenango Fuego Santa Maria Agua ";

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;

  typedef struct {
    logic [DIV_W-1:0] div;
    logic             loop;
    int               exp_lat;
    int               exp_period;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (done) done_cnt++;
  endtask

  task automatic wait_valid(input int max);
    int w;
    w = 0;
    while (!s_if.out_valid && w < max) begin
      tick();
      w++;
    end
    chk("valid_timeout", 32'(s_if.out_valid), 32'd1);
  endtask

  task automatic start_stream(input logic [DIV_W-1:0] d, input logic l);
    start     = 1'b1;
    div       = d;
    mode_loop = l;
    tick();
    start = 1'b0;
  endtask

  task automatic abort_check(input string name);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_valid"}, 32'(s_if.out_valid), 32'd0);
    chk({name, "_idx"}, 32'(idx), 32'd0);
  endtask

  // Full one-shot stream; optionally pokes start/mode_loop/div at idx 7.
  task automatic run_oneshot(input logic [DIV_W-1:0] d, input bit disturb);
    int t0;
    int tp;
    int dc0;
    dc0 = done_cnt;
    t0  = cyc;
    tp  = cyc;
    start_stream(d, 1'b0);
    for (int i = 0; i < 51; i++) begin
      wait_valid(int'(d) + 10);
      chk("stream_char", 32'(s_if.out_data), 32'(msg_s[i]));
      chk("stream_idx", 32'(idx), 32'(i));
      if (i == 0) chk("first_latency", 32'(cyc - t0), 32'(int'(d) + 2));
      else        chk("char_period", 32'(cyc - tp), 32'(int'(d) + 2));
      tp = cyc;
      if (disturb && i == 7) begin
        start     = 1'b1;
        mode_loop = 1'b1;
        div       = d + 16'd4;
      end
      tick();
      start = 1'b0;
    end
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_idx", 32'(idx), 32'd0);
    tick();
    chk("done_width", 32'(done), 32'd0);
    chk("done_count", 32'(done_cnt - dc0), 32'd1);
  endtask

  initial begin
    int tp;
    int t0;
    int dc0;

    vecs[0] = '{16'd0, 1'b0, 2, 2};
    vecs[1] = '{16'd1, 1'b0, 3, 3};
    vecs[2] = '{16'd3, 1'b1, 5, 5};
    vecs[3] = '{16'd6, 1'b0, 8, 8};

    // Reset held with start and out_ready asserted.
    rst_n = 1'b0;
    en = 1'b1;
    start = 1'b1;
    stop = 1'b0;
    mode_loop = 1'b0;
    div = '0;
    s_if.out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_data", 32'(s_if.out_data), 32'd0);
    chk("rst_valid", 32'(s_if.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_valid", 32'(s_if.out_valid), 32'd0);

    // Pacing table: latency, period and first three characters per divisor.
    for (int v = 0; v < 4; v++) begin
      t0 = cyc;
      start_stream(vecs[v].div, vecs[v].loop);
      wait_valid(40);
      chk("vec_latency", 32'(cyc - t0), 32'(vecs[v].exp_lat));
      chk("vec_char0", 32'(s_if.out_data), 32'h54);
      tp = cyc;
      tick();
      wait_valid(40);
      chk("vec_period1", 32'(cyc - tp), 32'(vecs[v].exp_period));
      chk("vec_char1", 32'(s_if.out_data), 32'h61);
      chk("vec_idx1", 32'(idx), 32'd1);
      tp = cyc;
      tick();
      wait_valid(40);
      chk("vec_period2", 32'(cyc - tp), 32'(vecs[v].exp_period));
      chk("vec_char2", 32'(s_if.out_data), 32'h6A);
      dc0 = done_cnt;
      abort_check("vec_stop_in_send");
      chk("vec_stop_no_done", 32'(done_cnt - dc0), 32'd0);
    end

    // Complete one-shot stream at div=0.
    run_oneshot(16'd0, 1'b0);

    // Backpressure on the second character.
    start_stream(16'd0, 1'b0);
    wait_valid(10);
    tick();
    s_if.out_ready = 1'b0;
    wait_valid(10);
    chk("bp_char", 32'(s_if.out_data), 32'h61);
    chk("bp_idx", 32'(idx), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_data", 32'(s_if.out_data), 32'h61);
      chk("bp_hold_valid", 32'(s_if.out_valid), 32'd1);
      chk("bp_hold_idx", 32'(idx), 32'd1);
    end
    // en low must not drop a pending character either.
    en = 1'b0;
    tick();
    chk("bp_en_low_valid", 32'(s_if.out_valid), 32'd1);
    en = 1'b1;
    s_if.out_ready = 1'b1;
    tick();
    wait_valid(10);
    chk("bp_next_char", 32'(s_if.out_data), 32'h6A);
    chk("bp_next_idx", 32'(idx), 32'd2);
    abort_check("bp_stop");

    // Loop mode wraps without done; stop in PACE.
    dc0 = done_cnt;
    start_stream(16'd0, 1'b1);
    for (int i = 0; i < 52; i++) begin
      wait_valid(10);
      chk("loop_char", 32'(s_if.out_data), 32'(msg_s[i % 51]));
      chk("loop_idx", 32'(idx), 32'(i % 51));
      tick();
    end
    chk("loop_no_done", 32'(done_cnt - dc0), 32'd0);
    chk("loop_pace_busy", 32'(busy), 32'd1);
    abort_check("loop_stop_in_pace");
    tick();
    chk("loop_stop_quiet", 32'(s_if.out_valid), 32'd0);
    chk("loop_stop_no_done", 32'(done_cnt - dc0), 32'd0);

    // Enable gap inside PACE stretches the period by the gap length.
    start_stream(16'd3, 1'b0);
    wait_valid(20);
    tp = cyc;
    tick();
    en = 1'b0;
    repeat (10) tick();
    en = 1'b1;
    wait_valid(30);
    chk("en_gap_period", 32'(cyc - tp), 32'd15);
    chk("en_gap_char", 32'(s_if.out_data), 32'h61);
    abort_check("en_gap_stop");

    // Mid-stream start/mode_loop/div changes are ignored.
    run_oneshot(16'd0, 1'b1);
    mode_loop = 1'b0;
    div = '0;

    // start with en low is ignored.
    en = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_no_en_busy", 32'(busy), 32'd0);
    en = 1'b1;
    tick();
    chk("start_no_en_busy2", 32'(busy), 32'd0);
    chk("start_no_en_valid", 32'(s_if.out_valid), 32'd0);

    // stop alone in IDLE does nothing; start+stop in IDLE starts.
    stop = 1'b1;
    tick();
    chk("idle_stop_busy", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("start_stop_busy", 32'(busy), 32'd1);

    // Asynchronous reset mid-stream clears outputs without a clock edge.
    wait_valid(10);
    dc0 = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(s_if.out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_data", 32'(s_if.out_data), 32'd0);
    chk("arst_idx", 32'(idx), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst_no_done", 32'(done_cnt - dc0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end
endmodule
